// File: rtl/gcd_stein_unit_pkg.sv
// rtl/gcd_stein_unit_pkg.sv - shared FSM encoding and cycle bound for the Stein GCD unit
// Contents:
//   IDLE_IDX..DONE_IDX : bit positions of the one-hot state vector
//   state_t            : one-hot states IDLE/STRIP/ITER/DONE
//   max_cycles(width)  : worst-case accept-to-result cycle count
package gcd_pkg;

  localparam int IDLE_IDX  = 0;
  localparam int STRIP_IDX = 1;
  localparam int ITER_IDX  = 2;
  localparam int DONE_IDX  = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'(1 << IDLE_IDX),
    STRIP = 4'(1 << STRIP_IDX),
    ITER  = 4'(1 << ITER_IDX),
    DONE  = 4'(1 << DONE_IDX)
  } state_t;

  // At most WIDTH-1 common factors of two are stripped, the strip exit takes one
  // cycle, and each odd/odd reduction removes at least one bit from one operand.
  function automatic int max_cycles(input int width);
    return 3 * width + 3;
  endfunction

endpackage

// File: rtl/gcd_stein_unit_if.sv
// rtl/gcd_stein_unit_if.sv - request/result handshake bundle for the Stein GCD unit
// Signals:
//   in_valid/in_ready/in_a/in_b : operand pair handshake (producer -> engine)
//   out_valid/out_ready         : result handshake (engine -> consumer)
//   out_gcd/out_cycles          : result value and accept-to-result cycle count
//   busy                        : engine is working on or holding a result
// Modports: master = producer/consumer side, slave = engine side.
interface gcd_stein_unit_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(max_cycles(WIDTH) + 1)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [CNT_W-1:0] out_cycles;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gcd, out_cycles, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gcd, out_cycles, busy
  );

endinterface

// File: rtl/gcd_stein_unit_step.sv
// rtl/gcd_stein_unit_step.sv - one combinational reduction step of binary GCD
// Ports:
//   a, b         in  WIDTH  current operands (at least one odd)
//   a_nxt, b_nxt out WIDTH  operands after one reduction step
//   equal        out 1      operands are equal (and odd): reduction finished
module gcd_stein_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             equal
);

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    equal = 1'b0;
    if (!a[0]) begin
      a_nxt = a >> 1;
    end else if (!b[0]) begin
      b_nxt = b >> 1;
    end else if (a > b) begin
      // Both odd, so the difference is even and the halving is exact; ordering
      // the operands first means the subtraction never borrows.
      a_nxt = (a - b) >> 1;
    end else if (b > a) begin
      b_nxt = (b - a) >> 1;
    end else begin
      equal = 1'b1;
    end
  end

endmodule

// File: rtl/gcd_stein_unit.sv
// rtl/gcd_stein_unit.sv - binary (Stein) GCD engine with valid/ready handshakes
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   synchronous, active-high reset; aborts any operation
//   bus  slave   operand/result handshake (see gcd_stein_unit_if)
// One operation in flight: IDLE accepts a pair, STRIP removes common factors of
// two, ITER reduces until the operands meet, DONE holds the result until taken.
module gcd_stein_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(max_cycles(WIDTH) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  gcd_stein_unit_if.slave   bus
);

  localparam int               K_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_cycles(WIDTH));

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [K_W-1:0]   k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] gcd_q;
  logic [CNT_W-1:0] cycles_q;

  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             equal;

  gcd_stein_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_q),
    .b     (b_q),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .equal (equal)
  );

  // cnt_q counts edges since the accept edge (the accept edge itself is 1), so the
  // result edge stores cnt_q + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      gcd_q    <= '0;
      cycles_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            k_q   <= '0;
            cnt_q <= CNT_W'(1);
            if (bus.in_a == '0 || bus.in_b == '0) begin
              gcd_q    <= bus.in_a | bus.in_b;
              cycles_q <= CNT_W'(1);
              state_q  <= DONE;
            end else begin
              state_q <= STRIP;
            end
          end
        end
        STRIP: begin
          assert (cnt_q < CNT_MAX);
          cnt_q <= cnt_q + CNT_W'(1);
          if (!a_q[0] && !b_q[0]) begin
            assert (k_q < K_W'(WIDTH - 1));
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + K_W'(1);
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          assert (cnt_q < CNT_MAX);
          cnt_q <= cnt_q + CNT_W'(1);
          if (equal) begin
            // The common odd part times 2^k cannot exceed the smaller operand.
            gcd_q    <= a_q << k_q;
            cycles_q <= cnt_q + CNT_W'(1);
            state_q  <= DONE;
          end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = state_q[IDLE_IDX];
  assign bus.busy       = !state_q[IDLE_IDX];
  assign bus.out_valid  = state_q[DONE_IDX];
  assign bus.out_gcd    = gcd_q;
  assign bus.out_cycles = cycles_q;

endmodule

// File: tb/tb_gcd_stein_unit.sv
// tb/tb_gcd_stein_unit.sv - self-checking bench for gcd_stein_unit (WIDTH 8 and 16)
module tb_gcd_stein_unit;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  gcd_stein_unit_if #(.WIDTH(8))  if8 ();
  gcd_stein_unit_if #(.WIDTH(16)) if16 ();

  gcd_stein_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8.slave));
  gcd_stein_unit #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));

  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold,
                     input string tag);
    int         meas;
    logic [7:0] exp;
    exp = 8'(ref_gcd(32'(a), 32'(b)));
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(if8.in_ready), 1);
    if8.in_valid  = 1'b1;
    if8.in_a      = a;
    if8.in_b      = b;
    if8.out_ready = (hold == 0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    if8.in_a     = 8'($urandom);
    if8.in_b     = 8'($urandom);
    meas = 1;
    while (!if8.out_valid && meas < 100) begin
      @(negedge clk);
      meas++;
    end
    check({tag, " out_valid"}, 32'(if8.out_valid), 1);
    check({tag, " gcd"}, 32'(if8.out_gcd), 32'(exp));
    check({tag, " cycles measured"}, 32'(if8.out_cycles), 32'(meas));
    check({tag, " cycles bound"}, 32'(meas <= 27), 1);
    check({tag, " in_ready busy"}, 32'(if8.in_ready), 0);
    check({tag, " busy"}, 32'(if8.busy), 1);
    if (a == 0 || b == 0) check({tag, " one cycle"}, 32'(meas), 1);
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = i[0];
      if8.in_a     = 8'($urandom);
      @(negedge clk);
      check({tag, " hold valid"}, 32'(if8.out_valid), 1);
      check({tag, " hold gcd"}, 32'(if8.out_gcd), 32'(exp));
      check({tag, " hold in_ready"}, 32'(if8.in_ready), 0);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready after"}, 32'(if8.in_ready), 1);
    check({tag, " valid after"}, 32'(if8.out_valid), 0);
    check({tag, " gcd kept"}, 32'(if8.out_gcd), 32'(exp));
    if8.out_ready = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b);
    int          meas;
    int          guard;
    logic [15:0] exp;
    exp = 16'(ref_gcd(32'(a), 32'(b)));
    if16.in_valid  = 1'b1;
    if16.in_a      = a;
    if16.in_b      = b;
    if16.out_ready = 1'($urandom);
    @(negedge clk);
    if16.in_valid = 1'b0;
    meas = 1;
    while (!if16.out_valid && meas < 200) begin
      if16.out_ready = 1'($urandom);
      @(negedge clk);
      meas++;
    end
    check("rnd gcd", 32'(if16.out_gcd), 32'(exp));
    check("rnd cycles", 32'(if16.out_cycles), 32'(meas));
    check("rnd bound", 32'(meas <= 51), 1);
    guard = 0;
    if16.out_ready = 1'($urandom);
    while (!if16.out_ready && guard < 20) begin
      @(negedge clk);
      guard++;
      if (if16.out_gcd !== exp) check("rnd hold gcd", 32'(if16.out_gcd), 32'(exp));
      if16.out_ready = 1'($urandom);
    end
    if16.out_ready = 1'b1;
    @(negedge clk);
    check("rnd idle", 32'(if16.in_ready), 1);
    if16.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.out_ready = 1'b0;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(if8.in_ready), 1);
    check("rst out_valid", 32'(if8.out_valid), 0);
    check("rst out_gcd", 32'(if8.out_gcd), 0);
    check("rst out_cycles", 32'(if8.out_cycles), 0);
    check("rst busy", 32'(if8.busy), 0);
    check("rst16 in_ready", 32'(if16.in_ready), 1);
    rst = 1'b0;

    op8(8'd48, 8'd18, 0, "48_18");
    op8(8'd0, 8'd0, 0, "0_0");
    op8(8'd0, 8'd35, 0, "0_35");
    op8(8'd35, 8'd0, 0, "35_0");
    op8(8'd128, 8'd64, 0, "128_64");
    check("128_64 k", 32'(u8.k_q), 6);
    op8(8'd255, 8'd255, 0, "255_255");
    op8(8'd255, 8'd1, 0, "255_1");
    op8(8'd254, 8'd127, 0, "254_127");
    op8(8'd12, 8'd8, 10, "bp_12_8");

    // Abort partway through the reduction of (210,45).
    @(negedge clk);
    if8.in_valid = 1'b1; if8.in_a = 8'd210; if8.in_b = 8'd45;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy before", 32'(if8.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 32'(if8.in_ready), 1);
    check("abort out_valid", 32'(if8.out_valid), 0);
    check("abort out_gcd", 32'(if8.out_gcd), 0);
    check("abort busy", 32'(if8.busy), 0);
    op8(8'd21, 8'd14, 0, "21_14");

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 31) == 0) ra = '0;
      if ($urandom_range(0, 31) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = rb << $urandom_range(0, 3);
      op16(ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
